// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared fetch-stage constants and FSM state encoding.
package if_fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic [2:0] {S_RESET, S_FETCH, S_FULL, S_DISCARD, S_ERR} state_t;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: output entry plus one skid entry toward decode, order preserving.
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_code,
  input  logic [31:0] push_pc,
  input  logic        push_err,
  output logic [31:0] inst_code,
  output logic [31:0] pc_addr,
  output logic        inst_valid,
  output logic        fetch_err
);
  logic [31:0] skid_code, skid_pc;
  logic        skid_err, skid_valid, adv;
  assign adv = !inst_valid || pop;
  // flush may carry a push so an error entry can land on the redirect edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {inst_code, pc_addr, fetch_err, inst_valid} <= {NOP, 32'h0, 1'b0, 1'b0};
      {skid_code, skid_pc, skid_err, skid_valid} <= {NOP, 32'h0, 1'b0, 1'b0};
    end else if (flush) begin
      inst_valid <= push;
      skid_valid <= 1'b0;
      if (push) {inst_code, pc_addr, fetch_err} <= {push_code, push_pc, push_err};
    end else if (adv) begin
      inst_valid <= skid_valid || push;
      if (skid_valid) begin
        {inst_code, pc_addr, fetch_err} <= {skid_code, skid_pc, skid_err};
        skid_valid <= push;
        if (push) {skid_code, skid_pc, skid_err} <= {push_code, push_pc, push_err};
      end else if (push) begin
        {inst_code, pc_addr, fetch_err} <= {push_code, push_pc, push_err};
      end
    end else if (push) begin
      {skid_code, skid_pc, skid_err} <= {push_code, push_pc, push_err};
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch FSM and PC, feeding decode through if_skid_buf.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_code,
  output logic [31:0] pc_addr,
  output logic        inst_valid,
  output logic        fetch_err
);
  state_t      state, state_n;
  logic [31:0] pc, pc_n, hold, hold_n, tgt, push_code, push_pc;
  logic        push, push_err, flush, resolve, tgt_mis;
  assign imem_req  = state == S_FETCH || state == S_DISCARD;
  assign imem_addr = state == S_DISCARD ? hold : pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
      pc    <= RESET_PC;
      hold  <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      hold  <= hold_n;
    end
  end
  // resolve: no request outstanding any more, so start at tgt or park on an error entry
  always_comb begin
    tgt       = redirect_valid ? redirect_addr : pc;
    tgt_mis   = tgt[1:0] != 2'b00;
    state_n   = state;
    pc_n      = pc;
    hold_n    = hold;
    flush     = 1'b0;
    push      = 1'b0;
    push_code = imem_rdata;
    push_pc   = pc;
    push_err  = 1'b0;
    resolve   = 1'b0;
    case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH: begin
        if (redirect_valid && !imem_ack) begin
          flush   = 1'b1;
          pc_n    = redirect_addr;
          hold_n  = pc;
          state_n = S_DISCARD;
        end else if (redirect_valid) begin
          resolve = 1'b1;
        end else if (imem_ack) begin
          pc_n    = pc + 32'd4;
          push    = 1'b1;
          state_n = inst_valid && stall ? S_FULL : S_FETCH;
        end
      end
      S_FULL: begin
        if (redirect_valid) resolve = 1'b1;
        else if (!stall) state_n = S_FETCH;
      end
      S_DISCARD: begin
        if (imem_ack) begin
          resolve = 1'b1;
        end else if (redirect_valid) begin
          flush = 1'b1;
          pc_n  = redirect_addr;
        end
      end
      S_ERR: resolve = redirect_valid;
      default: state_n = S_RESET;
    endcase
    if (resolve) begin
      flush     = redirect_valid;
      pc_n      = tgt;
      push      = tgt_mis;
      push_code = NOP;
      push_pc   = tgt;
      push_err  = 1'b1;
      state_n   = tgt_mis ? S_ERR : S_FETCH;
    end
  end
  if_skid_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .pop        (!stall),
    .push_code  (push_code),
    .push_pc    (push_pc),
    .push_err   (push_err),
    .inst_code  (inst_code),
    .pc_addr    (pc_addr),
    .inst_valid (inst_valid),
    .fetch_err  (fetch_err)
  );
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: stall  input  1  decode stage cannot accept an entry this cycle.
REQ-005 SHALL have port: redirect_valid  input  1  one-cycle pulse, change fetch PC (branch/jump/exception).
REQ-006 SHALL have port: redirect_addr  input  32  new fetch PC, sampled when redirect_valid=1.
REQ-007 SHALL have port: imem_req  output  1  instruction memory request.
REQ-008 SHALL have port: imem_addr  output  32  request address.
REQ-009 SHALL have port: imem_ack  input  1  response valid, one cycle per request.
REQ-010 SHALL have port: imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 SHALL have port: inst_code  output  32  fetched instruction to decode.
REQ-012 SHALL have port: pc_addr  output  32  address of inst_code.
REQ-013 SHALL have port: inst_valid  output  1  inst_code/pc_addr/fetch_err hold a live entry.
REQ-014 SHALL have port: fetch_err  output  1  entry is a misaligned-fetch error, meaningful only with inst_valid=1.

Function
REQ-015 SHALL implement states RESET, FETCH, FULL, DISCARD, ERR; imem_req=1 exactly in FETCH and DISCARD.
REQ-016 SHALL move RESET->FETCH on the first rising edge with rst_n high; redirect_valid ignored in RESET.
REQ-017 SHALL drive imem_addr from the PC register; while imem_req=1 and imem_ack=0, imem_addr stays stable and imem_req stays high.
REQ-018 SHALL treat an entry as consumed on an edge where inst_valid=1 and stall=0.
REQ-019 SHALL buffer one output entry plus one skid entry; order preserved, no loss, no duplication.
REQ-020 SHALL, on ack in FETCH without redirect: PC <= PC+4 (modulo 2^32); data goes to output if output empty, being consumed or refilled from skid that edge, else to skid.
REQ-021 SHALL enter FULL when the skid holds an entry; leave FULL to FETCH on the edge the skid moves to output.
REQ-022 SHALL clear inst_valid on a consume edge when neither skid nor ack supplies a new entry.
REQ-023 SHALL, on redirect_valid, load PC with redirect_addr and invalidate output and skid on that edge, redirect overriding stall.
REQ-024 SHALL, on redirect with a request pending and no ack that cycle, enter DISCARD: hold old address until ack, drop the data, then FETCH at the new PC.
REQ-025 SHALL, on redirect coinciding with ack, drop the ack data and request the new PC next cycle.
REQ-026 SHALL, on redirect during DISCARD, update PC and remain in DISCARD.
REQ-027 SHALL, for redirect_addr[1:0]!=0, never request that address; after any DISCARD completes, place one entry (inst_code=0, pc_addr=redirect_addr, fetch_err=1), enter ERR with imem_req=0, leave ERR only on redirect.
REQ-028 SHALL keep latency ack-to-inst_valid at one edge when output is free.

Reset
REQ-029 SHALL on rst_n low asynchronously set: state RESET, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_code=0, pc_addr=0, inst_valid=0, fetch_err=0, skid empty.
REQ-030 SHALL abandon any outstanding request on reset; a late imem_ack after reset is ignored until FETCH.

Structure
REQ-031 SHALL place RESET_PC default, state encodings and the NOP word (32'h0) in the shared defs package.
REQ-032 SHALL isolate the output+skid entry pair in one sub-module, if_skid_buf; FSM and PC stay in if_fetch.

Verification
REQ-033 SHALL cover: reset release, ack every cycle, stall=0 -> pc_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles, inst_valid=1.
REQ-034 SHALL cover: ack latency 3 cycles -> imem_req high and imem_addr stable 3 cycles, one inst_valid entry per word.
REQ-035 SHALL cover: stall high 4 cycles, ack immediate -> FULL reached, imem_req=0; after release both words emitted in order, no gap in PC.
REQ-036 SHALL cover: redirect to 0x80000100 while 0xBFC00008 pending, ack 2 cycles later -> word dropped, inst_valid=0 next cycle, next imem_addr 0x80000100.
REQ-037 SHALL cover: redirect to 0x80000102 -> no request to it; one entry fetch_err=1, pc_addr=0x80000102, inst_code=0; imem_req=0 until redirect to 0x80000200.
REQ-038 SHALL cover: rst_n low mid-request -> all outputs at reset values immediately, first request at 0xBFC00000 after release.
